axi_slave_reg_slice: RTL and testbench

Parametrised AXI4 register slice inserted between the bus-side slave port (bridge or crossbar output) and a slave device such as SRAM or ROM wrapper. It cuts combinational timing paths on all five channels (AW, W, B, AR, R). Each channel is independently configurable as bypass, full (2-entry skid, full throughput) or light (1-entry, half throughput). Ordering and payload are preserved bit-exactly, with no reordering or merging.

---
 rtl/axi_slice_pkg.sv | 17 +
 rtl/axi_slice_chan.sv | 107 ++++++++++
 rtl/axi_slave_reg_slice.sv | 150 +++++++++++++++
 tb/tb_axi_slave_reg_slice.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI register slice: per-channel slice mode and the
// occupancy state used by the registered slice modes.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS,
    SLICE_FULL,
    SLICE_LIGHT
  } slice_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } slice_state_e;

endpackage

// File: rtl/axi_slice_chan.sv
// Generic valid/ready register slice for one AXI channel.
// The mode selects wires (bypass), a 2-entry skid (full) or a 1-entry buffer (light).
module axi_slice_chan
  import axi_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             occupied
);

  slice_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_hs, out_hs;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = in_ready_q;
    in_hs      = in_valid && in_ready_q;
    out_hs     = (state_q != ST_EMPTY) && out_ready;

    if (MODE == SLICE_FULL) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            main_d  = in_data;
            state_d = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (in_hs && !out_hs) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (!in_hs && out_hs) begin
            state_d = ST_EMPTY;
          end else if (in_hs && out_hs) begin
            main_d = in_data;
          end
        end
        ST_FULL: begin
          if (out_hs) begin
            main_d  = skid_q;
            state_d = ST_MAIN;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Ready is computed from the next state so it can be registered
      // without a path from out_ready.
      in_ready_d = (state_d != ST_FULL);
    end else if (MODE == SLICE_LIGHT) begin
      if (state_q == ST_EMPTY) begin
        if (in_hs) begin
          main_d  = in_data;
          state_d = ST_MAIN;
        end
      end else if (out_hs) begin
        state_d = ST_EMPTY;
      end
      in_ready_d = (state_d == ST_EMPTY);
    end else begin
      state_d    = ST_EMPTY;
      in_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    if (MODE == SLICE_BYPASS) begin
      out_valid = in_valid;
      in_ready  = out_ready;
      out_data  = in_data;
      occupied  = 1'b0;
    end else begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = in_ready_q;
      out_data  = main_q;
      occupied  = (state_q != ST_EMPTY);
    end
  end

endmodule

// File: rtl/axi_slave_reg_slice.sv
// AXI4 register slice between a bus-side slave port and a slave device.
// Each channel is one axi_slice_chan; B and R run from the m_ side to the s_ side.
module axi_slave_reg_slice
  import axi_slice_pkg::*;
#(
  parameter int unsigned ID_W    = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned SIZE_W  = 3,
  parameter slice_mode_e AW_MODE = SLICE_FULL,
  parameter slice_mode_e W_MODE  = SLICE_FULL,
  parameter slice_mode_e AR_MODE = SLICE_FULL,
  parameter slice_mode_e B_MODE  = SLICE_FULL,
  parameter slice_mode_e R_MODE  = SLICE_FULL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_AWID,
  input  logic [ADDR_W-1:0]   s_AWADDR,
  input  logic [LEN_W-1:0]    s_AWLEN,
  input  logic [SIZE_W-1:0]   s_AWSIZE,
  input  logic [1:0]          s_AWBURST,
  input  logic                s_AWVALID,
  output logic                s_AWREADY,
  input  logic [DATA_W-1:0]   s_WDATA,
  input  logic [DATA_W/8-1:0] s_WSTRB,
  input  logic                s_WLAST,
  input  logic                s_WVALID,
  output logic                s_WREADY,
  output logic [ID_W-1:0]     s_BID,
  output logic [1:0]          s_BRESP,
  output logic                s_BVALID,
  input  logic                s_BREADY,
  input  logic [ID_W-1:0]     s_ARID,
  input  logic [ADDR_W-1:0]   s_ARADDR,
  input  logic [LEN_W-1:0]    s_ARLEN,
  input  logic [SIZE_W-1:0]   s_ARSIZE,
  input  logic [1:0]          s_ARBURST,
  input  logic                s_ARVALID,
  output logic                s_ARREADY,
  output logic [ID_W-1:0]     s_RID,
  output logic [DATA_W-1:0]   s_RDATA,
  output logic [1:0]          s_RRESP,
  output logic                s_RLAST,
  output logic                s_RVALID,
  input  logic                s_RREADY,
  output logic [ID_W-1:0]     m_AWID,
  output logic [ADDR_W-1:0]   m_AWADDR,
  output logic [LEN_W-1:0]    m_AWLEN,
  output logic [SIZE_W-1:0]   m_AWSIZE,
  output logic [1:0]          m_AWBURST,
  output logic                m_AWVALID,
  input  logic                m_AWREADY,
  output logic [DATA_W-1:0]   m_WDATA,
  output logic [DATA_W/8-1:0] m_WSTRB,
  output logic                m_WLAST,
  output logic                m_WVALID,
  input  logic                m_WREADY,
  input  logic [ID_W-1:0]     m_BID,
  input  logic [1:0]          m_BRESP,
  input  logic                m_BVALID,
  output logic                m_BREADY,
  output logic [ID_W-1:0]     m_ARID,
  output logic [ADDR_W-1:0]   m_ARADDR,
  output logic [LEN_W-1:0]    m_ARLEN,
  output logic [SIZE_W-1:0]   m_ARSIZE,
  output logic [1:0]          m_ARBURST,
  output logic                m_ARVALID,
  input  logic                m_ARREADY,
  input  logic [ID_W-1:0]     m_RID,
  input  logic [DATA_W-1:0]   m_RDATA,
  input  logic [1:0]          m_RRESP,
  input  logic                m_RLAST,
  input  logic                m_RVALID,
  output logic                m_RREADY,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned A_PW   = ID_W + ADDR_W + LEN_W + SIZE_W + 2;
  localparam int unsigned W_PW   = DATA_W + STRB_W + 1;
  localparam int unsigned B_PW   = ID_W + 2;
  localparam int unsigned R_PW   = ID_W + DATA_W + 2 + 1;

  logic aw_occ, w_occ, b_occ, ar_occ, r_occ;

  axi_slice_chan #(.WIDTH(A_PW), .MODE(AW_MODE)) u_aw (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_AWVALID),
    .in_ready  (s_AWREADY),
    .in_data   ({s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST}),
    .out_valid (m_AWVALID),
    .out_ready (m_AWREADY),
    .out_data  ({m_AWID, m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST}),
    .occupied  (aw_occ)
  );

  axi_slice_chan #(.WIDTH(W_PW), .MODE(W_MODE)) u_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_WVALID),
    .in_ready  (s_WREADY),
    .in_data   ({s_WDATA, s_WSTRB, s_WLAST}),
    .out_valid (m_WVALID),
    .out_ready (m_WREADY),
    .out_data  ({m_WDATA, m_WSTRB, m_WLAST}),
    .occupied  (w_occ)
  );

  axi_slice_chan #(.WIDTH(B_PW), .MODE(B_MODE)) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_BVALID),
    .in_ready  (m_BREADY),
    .in_data   ({m_BID, m_BRESP}),
    .out_valid (s_BVALID),
    .out_ready (s_BREADY),
    .out_data  ({s_BID, s_BRESP}),
    .occupied  (b_occ)
  );

  axi_slice_chan #(.WIDTH(A_PW), .MODE(AR_MODE)) u_ar (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_ARVALID),
    .in_ready  (s_ARREADY),
    .in_data   ({s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST}),
    .out_valid (m_ARVALID),
    .out_ready (m_ARREADY),
    .out_data  ({m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST}),
    .occupied  (ar_occ)
  );

  axi_slice_chan #(.WIDTH(R_PW), .MODE(R_MODE)) u_r (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_RVALID),
    .in_ready  (m_RREADY),
    .in_data   ({m_RID, m_RDATA, m_RRESP, m_RLAST}),
    .out_valid (s_RVALID),
    .out_ready (s_RREADY),
    .out_data  ({s_RID, s_RDATA, s_RRESP, s_RLAST}),
    .occupied  (r_occ)
  );

  assign busy = aw_occ | w_occ | b_occ | ar_occ | r_occ;

endmodule

// File: tb/tb_axi_slave_reg_slice.sv
// Self-checking bench for axi_slave_reg_slice with AW/AR/R full, W light, B bypass.
module tb_axi_slave_reg_slice;
  import axi_slice_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_AWID = '0, m_AWID;
  logic [31:0] s_AWADDR = '0, m_AWADDR;
  logic [3:0]  s_AWLEN = '0, m_AWLEN;
  logic [2:0]  s_AWSIZE = '0, m_AWSIZE;
  logic [1:0]  s_AWBURST = '0, m_AWBURST;
  logic        s_AWVALID = 1'b0, s_AWREADY, m_AWVALID, m_AWREADY = 1'b0;
  logic [31:0] s_WDATA = '0, m_WDATA;
  logic [3:0]  s_WSTRB = '0, m_WSTRB;
  logic        s_WLAST = 1'b0, m_WLAST;
  logic        s_WVALID = 1'b0, s_WREADY, m_WVALID, m_WREADY = 1'b0;
  logic [7:0]  s_BID, m_BID = '0;
  logic [1:0]  s_BRESP, m_BRESP = '0;
  logic        s_BVALID, s_BREADY = 1'b0, m_BVALID = 1'b0, m_BREADY;
  logic [7:0]  s_ARID = '0, m_ARID;
  logic [31:0] s_ARADDR = '0, m_ARADDR;
  logic [3:0]  s_ARLEN = '0, m_ARLEN;
  logic [2:0]  s_ARSIZE = '0, m_ARSIZE;
  logic [1:0]  s_ARBURST = '0, m_ARBURST;
  logic        s_ARVALID = 1'b0, s_ARREADY, m_ARVALID, m_ARREADY = 1'b0;
  logic [7:0]  s_RID, m_RID = '0;
  logic [31:0] s_RDATA, m_RDATA = '0;
  logic [1:0]  s_RRESP, m_RRESP = '0;
  logic        s_RLAST, m_RLAST = 1'b0;
  logic        s_RVALID, s_RREADY = 1'b0, m_RVALID = 1'b0, m_RREADY;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } rbeat_t;

  axi_slave_reg_slice #(
    .ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .SIZE_W(3),
    .AW_MODE(SLICE_FULL), .W_MODE(SLICE_LIGHT), .AR_MODE(SLICE_FULL),
    .B_MODE(SLICE_BYPASS), .R_MODE(SLICE_FULL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_AWID(s_AWID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_AWBURST(s_AWBURST), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST), .s_WVALID(s_WVALID),
    .s_WREADY(s_WREADY),
    .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .m_AWID(m_AWID), .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
    .m_AWBURST(m_AWBURST), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID),
    .m_WREADY(m_WREADY),
    .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
    .m_ARBURST(m_ARBURST), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
    .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dev_data(input logic [31:0] addr, input int unsigned beat);
    return addr + beat * 32'h0101_0010;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s_BREADY = 1'b1;
    repeat (3) step();
    checks++;
    if ({m_AWVALID, m_WVALID, m_ARVALID, s_RVALID, s_BVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 00000", {m_AWVALID, m_WVALID, m_ARVALID, s_RVALID, s_BVALID});
    end
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY, m_RREADY} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", {s_AWREADY, s_WREADY, s_ARREADY, m_RREADY});
    end
    checks++;
    if (m_BREADY !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bready_busy: got %b%b want 10", m_BREADY, busy);
    end
    checks++;
    if ({m_AWADDR, m_WDATA, m_ARADDR, s_RDATA} !== 128'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h want 0", {m_AWADDR, m_WDATA, m_ARADDR, s_RDATA});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY, m_RREADY} !== 4'b1111) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 1111", {s_AWREADY, s_WREADY, s_ARREADY, m_RREADY});
    end
  endtask

  task automatic test_full_stream();
    logic [48:0] exp_aw [8];
    m_AWREADY = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        s_AWVALID = 1'b1;
        s_AWADDR  = 32'(4 * i);
        s_AWID    = 8'($urandom);
        s_AWLEN   = 4'($urandom);
        s_AWSIZE  = 3'($urandom);
        s_AWBURST = 2'($urandom);
        exp_aw[i] = {s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST};
      end else begin
        s_AWVALID = 1'b0;
      end
      #1;
      if (i < 8) begin
        checks++;
        if (s_AWREADY !== 1'b1) begin
          errors++;
          $display("FAIL aw_stream_ready[%0d]: got %b want 1", i, s_AWREADY);
        end
      end
      checks++;
      if (i == 0) begin
        if (m_AWVALID !== 1'b0) begin
          errors++;
          $display("FAIL aw_stream_first: got valid %b want 0", m_AWVALID);
        end
      end else if (m_AWVALID !== 1'b1 ||
                   {m_AWID, m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST} !== exp_aw[i-1]) begin
        errors++;
        $display("FAIL aw_stream_out[%0d]: got v=%b %h want v=1 %h", i - 1, m_AWVALID,
                 {m_AWID, m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST}, exp_aw[i-1]);
      end
      step();
    end
    checks++;
    if (m_AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL aw_stream_drain: got valid %b want 0", m_AWVALID);
    end
  endtask

  task automatic test_backpressure();
    int unsigned sent = 0, rcv = 0, idx = 0;
    logic hs_m, hs_s, stall;
    logic [31:0] held_data;
    m_RVALID = 1'b1;
    m_RDATA  = 32'hA0;
    m_RID    = 8'd0;
    m_RLAST  = 1'b0;
    m_RRESP  = 2'b00;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      s_RREADY = (c % 3 == 0);
      #1;
      hs_m = m_RVALID && m_RREADY;
      hs_s = s_RVALID && s_RREADY;
      stall = s_RVALID && !s_RREADY;
      held_data = s_RDATA;
      if (hs_s) begin
        checks++;
        if (s_RDATA !== 32'(32'hA0 + rcv) || s_RLAST !== (rcv == 7) || s_RID !== 8'(rcv)) begin
          errors++;
          $display("FAIL r_bp_beat[%0d]: got id=%h d=%h l=%b want id=%h d=%h l=%b", rcv, s_RID,
                   s_RDATA, s_RLAST, 8'(rcv), 32'(32'hA0 + rcv), (rcv == 7));
        end
        rcv++;
      end
      step();
      if (hs_m) begin
        sent++;
        idx++;
        if (idx < 8) begin
          m_RDATA = 32'(32'hA0 + idx);
          m_RID   = 8'(idx);
          m_RLAST = (idx == 7);
        end else begin
          m_RVALID = 1'b0;
          m_RLAST  = 1'b0;
        end
      end
      checks++;
      if (m_RREADY !== (sent - rcv < 2) || s_RVALID !== (sent != rcv)) begin
        errors++;
        $display("FAIL r_bp_occupancy: got mready=%b svalid=%b want %b %b (held %0d)", m_RREADY,
                 s_RVALID, (sent - rcv < 2), (sent != rcv), sent - rcv);
      end
      if (stall) begin
        checks++;
        if (s_RDATA !== held_data) begin
          errors++;
          $display("FAIL r_bp_stable: got %h want %h", s_RDATA, held_data);
        end
      end
    end
    s_RREADY = 1'b0;
    checks++;
    if (rcv != 8 || sent != 8) begin
      errors++;
      $display("FAIL r_bp_count: got rcv=%0d sent=%0d want 8 8", rcv, sent);
    end
  endtask

  task automatic test_light();
    logic [31:0] wd [4];
    int unsigned sidx = 0, ridx = 0;
    logic hs_in;
    for (int b = 0; b < 4; b++) wd[b] = $urandom;
    m_WREADY = 1'b1;
    s_WSTRB  = 4'hF;
    for (int j = 0; j <= 8; j++) begin
      s_WVALID = (sidx < 4);
      s_WDATA  = (sidx < 4) ? wd[sidx] : 32'h0;
      s_WLAST  = (sidx == 3);
      #1;
      hs_in = s_WVALID && s_WREADY;
      if (j < 8) begin
        checks++;
        if (s_WREADY !== (j % 2 == 0)) begin
          errors++;
          $display("FAIL w_light_ready[%0d]: got %b want %b", j, s_WREADY, (j % 2 == 0));
        end
      end
      checks++;
      if (m_WVALID !== (j % 2 == 1)) begin
        errors++;
        $display("FAIL w_light_valid[%0d]: got %b want %b", j, m_WVALID, (j % 2 == 1));
      end else if (m_WVALID) begin
        checks++;
        if (m_WDATA !== wd[ridx] || m_WSTRB !== 4'hF || m_WLAST !== (ridx == 3)) begin
          errors++;
          $display("FAIL w_light_beat[%0d]: got %h %h %b want %h f %b", ridx, m_WDATA, m_WSTRB,
                   m_WLAST, wd[ridx], (ridx == 3));
        end
        ridx++;
      end
      step();
      if (hs_in) sidx++;
    end
    s_WVALID = 1'b0;
    s_WLAST  = 1'b0;
    checks++;
    if (ridx != 4) begin
      errors++;
      $display("FAIL w_light_count: got %0d want 4", ridx);
    end
  endtask

  task automatic test_bypass();
    for (int k = 0; k < 6; k++) begin
      m_BVALID = (k == 0) ? 1'b1 : 1'($urandom);
      m_BID    = (k == 0) ? 8'h03 : 8'($urandom);
      m_BRESP  = (k == 0) ? 2'b00 : 2'($urandom);
      s_BREADY = 1'($urandom);
      #1;
      checks++;
      if (s_BVALID !== m_BVALID || s_BID !== m_BID || s_BRESP !== m_BRESP || m_BREADY !== s_BREADY) begin
        errors++;
        $display("FAIL b_bypass[%0d]: got v=%b id=%h r=%h rdy=%b want v=%b id=%h r=%h rdy=%b", k,
                 s_BVALID, s_BID, s_BRESP, m_BREADY, m_BVALID, m_BID, m_BRESP, s_BREADY);
      end
      step();
    end
    m_BVALID = 1'b0;
    s_BREADY = 1'b1;
  endtask

  task automatic test_reset_mid();
    m_ARREADY = 1'b0;
    s_ARVALID = 1'b1;
    s_ARADDR  = 32'h40;
    step();
    s_ARADDR  = 32'h44;
    step();
    s_ARVALID = 1'b0;
    #1;
    checks++;
    if (s_ARREADY !== 1'b0 || busy !== 1'b1 || m_ARVALID !== 1'b1 || m_ARADDR !== 32'h40) begin
      errors++;
      $display("FAIL ar_fill: got rdy=%b busy=%b v=%b a=%h want 0 1 1 00000040", s_ARREADY,
               busy, m_ARVALID, m_ARADDR);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({m_AWVALID, m_WVALID, m_ARVALID, s_RVALID, busy} !== 5'b0 ||
        {s_AWREADY, s_WREADY, s_ARREADY, m_RREADY} !== 4'b0 || m_ARADDR !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b a=%h want 00000 0000 0",
               {m_AWVALID, m_WVALID, m_ARVALID, s_RVALID, busy},
               {s_AWREADY, s_WREADY, s_ARREADY, m_RREADY}, m_ARADDR);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({s_AWREADY, s_WREADY, s_ARREADY, m_RREADY} !== 4'b1111 || m_ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got rdy=%b v=%b want 1111 0",
               {s_AWREADY, s_WREADY, s_ARREADY, m_RREADY}, m_ARVALID);
    end
    m_ARREADY = 1'b1;
    s_ARVALID = 1'b1;
    s_ARADDR  = 32'h100;
    step();
    s_ARVALID = 1'b0;
    #1;
    checks++;
    if (m_ARVALID !== 1'b1 || m_ARADDR !== 32'h100) begin
      errors++;
      $display("FAIL ar_fresh: got v=%b a=%h want 1 00000100", m_ARVALID, m_ARADDR);
    end
    step();
    checks++;
    if (m_ARVALID !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_fresh_drain: got v=%b busy=%b want 0 0", m_ARVALID, busy);
    end
  endtask

  task automatic test_mixed_reads();
    localparam int unsigned N = 1000;
    rbeat_t exp_q[$];
    rbeat_t dev_q[$];
    int unsigned budget = cyc + 40000;
    int unsigned rcv = 0;
    s_ARLEN   = 4'd3;
    s_ARSIZE  = 3'd2;
    s_ARBURST = 2'b01;
    fork
      begin : master
        int unsigned issued = 0;
        logic hs;
        while (issued < N && cyc < budget) begin
          @(negedge clk);
          hs = s_ARVALID && s_ARREADY;
          @(posedge clk);
          #1;
          if (hs) begin
            for (int unsigned b = 0; b < 4; b++)
              exp_q.push_back('{id: s_ARID, data: dev_data(s_ARADDR, b), last: (b == 3)});
            issued++;
            s_ARVALID = 1'b0;
          end
          if (!s_ARVALID && issued < N && $urandom_range(0, 3) != 0) begin
            s_ARVALID = 1'b1;
            s_ARID    = 8'($urandom);
            s_ARADDR  = {$urandom} & 32'hFFFF_FFF0;
          end
        end
        s_ARVALID = 1'b0;
      end
      begin : device
        int unsigned sent = 0;
        logic ar_hs, r_hs;
        logic [7:0] a_id;
        logic [31:0] a_addr;
        logic [3:0] a_len;
        rbeat_t nb;
        while (sent < 4 * N && cyc < budget) begin
          @(negedge clk);
          ar_hs  = m_ARVALID && m_ARREADY;
          r_hs   = m_RVALID && m_RREADY;
          a_id   = m_ARID;
          a_addr = m_ARADDR;
          a_len  = m_ARLEN;
          @(posedge clk);
          #1;
          if (ar_hs)
            for (int unsigned b = 0; b <= a_len; b++)
              dev_q.push_back('{id: a_id, data: dev_data(a_addr, b), last: (b == a_len)});
          if (r_hs) begin
            m_RVALID = 1'b0;
            sent++;
          end
          if (!m_RVALID && dev_q.size() > 0 && $urandom_range(0, 4) != 0) begin
            nb = dev_q.pop_front();
            m_RVALID = 1'b1;
            m_RID    = nb.id;
            m_RDATA  = nb.data;
            m_RLAST  = nb.last;
            m_RRESP  = 2'b00;
          end
          m_ARREADY = 1'($urandom);
        end
        m_RVALID  = 1'b0;
        m_ARREADY = 1'b0;
      end
      begin : sink
        logic hs;
        rbeat_t got, want;
        while (rcv < 4 * N && cyc < budget) begin
          @(negedge clk);
          hs  = s_RVALID && s_RREADY;
          got = '{id: s_RID, data: s_RDATA, last: s_RLAST};
          @(posedge clk);
          #1;
          if (hs) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL mixed_extra_beat: got %h want none", got);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                errors++;
                $display("FAIL mixed_beat[%0d]: got %h want %h", rcv, got, want);
              end
            end
            rcv++;
          end
          s_RREADY = 1'($urandom);
        end
        s_RREADY = 1'b0;
      end
    join
    checks++;
    if (rcv != 4 * N || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mixed_count: got rcv=%0d pending=%0d want %0d 0", rcv, exp_q.size(), 4 * N);
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_light();
    test_bypass();
    test_reset_mid();
    test_mixed_reads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
